mmu_xlate: RTL and testbench

CPU-side address translation front end placed between the CPU load/store port and the system memory bus; it is the consumer of the TLB block's lookup interface. Each CPU request is translated when paging is enabled: virtual address to TLB, wait for `v_ack`, check the returned PTE, then issue the bus access at `{pte[31:12], vaddr[11:0]}`. Faults abort the access and are reported back to the CPU, with the faulting virtual address latched.

---
 rtl/mmu_pkg.sv | 16 +
 rtl/mmu_pte_check.sv | 32 +++
 rtl/mmu_xlate.sv | 139 +++++++++++++
 tb/tb_mmu_xlate.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// Shared definitions for the CPU-side address translation front end.
// Page size is fixed at 4 KiB. The PTE carries a valid bit and a writable bit.
package mmu_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_ACCESS = 2'd2,
      S_DONE   = 2'd3
   } mmu_state_t;

   localparam int PAGE_SHIFT = 12;
   localparam int PTE_V      = 0;
   localparam int PTE_W      = 1;

endpackage

// File: rtl/mmu_pte_check.sv
// Combinational PTE check: decides whether a translated access faults and
// builds the physical address from the PTE frame and the page offset.
// Build option: MMU_WRITE_PROTECT_EN makes writes to non-writable pages fault.
module mmu_pte_check
   import mmu_pkg::*;
(
   input  logic [31:0]           pte,
   input  logic                  sticky_fault,
   input  logic                  we,
   input  logic [PAGE_SHIFT-1:0] offset,
   output logic                  fault,
   output logic [31:0]           paddr
);

   logic unused_bits;

`ifdef MMU_WRITE_PROTECT_EN
   assign unused_bits = ^pte[PAGE_SHIFT-1:2];
`else
   assign unused_bits = ^{pte[PAGE_SHIFT-1:2], pte[PTE_W], we};
`endif

   // Fault on the sticky TLB flag, an invalid page, or (optionally) a write to a read-only page.
   always_comb begin
      fault = sticky_fault | ~pte[PTE_V];
`ifdef MMU_WRITE_PROTECT_EN
      fault = fault | (we & ~pte[PTE_W]);
`endif
      paddr = {pte[31:PAGE_SHIFT], offset};
   end

endmodule

// File: rtl/mmu_xlate.sv
// CPU-side address translation front end between the CPU load/store port
// and the memory bus; consumes the TLB lookup interface.
// Build option: MMU_WRITE_PROTECT_EN (handled inside mmu_pte_check).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a CPU read/write request
// S_LOOKUP | TLB lookup outstanding for the latched virtual address
// S_ACCESS | bus strobe asserted at the latched physical address
// S_DONE   | one-cycle completion (and fault) pulse back to the CPU
module mmu_xlate
   import mmu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        paging_en_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_rd_i,
   input  logic        cpu_we_i,
   output logic [31:0] cpu_data_o,
   output logic        cpu_ack_o,
   output logic        cpu_fault_o,
   output logic [31:0] fault_addr_o,
   output logic [31:0] tlb_addr_o,
   output logic        tlb_lookup_o,
   input  logic [31:0] tlb_ent_i,
   input  logic        tlb_ack_i,
   input  logic        tlb_fault_i,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   output logic        mem_rd_o,
   output logic        mem_we_o,
   input  logic        mem_ack_i
);

   mmu_state_t state, state_nx;

   logic [31:0] vaddr_q, wdata_q, paddr_q, rdata_q, faddr_q;
   logic        we_q, fault_q;
   logic        chk_fault;
   logic [31:0] chk_paddr;
   logic        req;

   assign req = cpu_rd_i | cpu_we_i;

   mmu_pte_check u_pte_check (
      .pte          (tlb_ent_i),
      .sticky_fault (tlb_fault_i),
      .we           (we_q),
      .offset       (vaddr_q[PAGE_SHIFT-1:0]),
      .fault        (chk_fault),
      .paddr        (chk_paddr)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state and strobe decode; TLB acks outside S_LOOKUP are ignored.
   always_comb begin
      state_nx     = state;
      tlb_lookup_o = 1'b0;
      mem_rd_o     = 1'b0;
      mem_we_o     = 1'b0;
      cpu_ack_o    = 1'b0;
      cpu_fault_o  = 1'b0;
      case (state)
         S_IDLE: begin
            if (req) state_nx = paging_en_i ? S_LOOKUP : S_ACCESS;
         end
         S_LOOKUP: begin
            tlb_lookup_o = 1'b1;
            if (tlb_ack_i) state_nx = chk_fault ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            mem_rd_o = ~we_q;
            mem_we_o = we_q;
            if (mem_ack_i) state_nx = S_DONE;
         end
         S_DONE: begin
            cpu_ack_o   = 1'b1;
            cpu_fault_o = fault_q;
            state_nx    = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Request, translation and result registers; a write wins over a simultaneous read.
   always_ff @(posedge clk) begin
      if (rst) begin
         vaddr_q <= '0;
         wdata_q <= '0;
         paddr_q <= '0;
         rdata_q <= '0;
         faddr_q <= '0;
         we_q    <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  vaddr_q <= cpu_addr_i;
                  wdata_q <= cpu_data_i;
                  paddr_q <= cpu_addr_i;
                  we_q    <= cpu_we_i;
                  fault_q <= 1'b0;
               end
            end
            S_LOOKUP: begin
               if (tlb_ack_i) begin
                  if (chk_fault) begin
                     fault_q <= 1'b1;
                     faddr_q <= vaddr_q;
                     rdata_q <= '0;
                  end else begin
                     paddr_q <= chk_paddr;
                  end
               end
            end
            S_ACCESS: begin
               if (mem_ack_i) rdata_q <= we_q ? 32'd0 : mem_data_i;
            end
            default: ;
         endcase
      end
   end

   assign cpu_data_o   = rdata_q;
   assign fault_addr_o = faddr_q;
   assign tlb_addr_o   = vaddr_q;
   assign mem_addr_o   = paddr_q;
   assign mem_data_o   = wdata_q;

endmodule

// File: tb/tb_mmu_xlate.sv
// Self-checking bench for mmu_xlate: the bench plays CPU, TLB and memory,
// and predicts each access outcome from the translation rules.
module tb_mmu_xlate;

`ifdef MMU_WRITE_PROTECT_EN
   localparam bit WP_ON = 1'b1;
`else
   localparam bit WP_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        paging_en_i;
   logic [31:0] cpu_addr_i, cpu_data_i;
   logic        cpu_rd_i, cpu_we_i;
   logic [31:0] cpu_data_o;
   logic        cpu_ack_o, cpu_fault_o;
   logic [31:0] fault_addr_o, tlb_addr_o;
   logic        tlb_lookup_o;
   logic [31:0] tlb_ent_i;
   logic        tlb_ack_i, tlb_fault_i;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic        mem_rd_o, mem_we_o, mem_ack_i;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_faddr = 32'd0;

   always #5 clk = ~clk;

   mmu_xlate dut (
      .clk          (clk),
      .rst          (rst),
      .paging_en_i  (paging_en_i),
      .cpu_addr_i   (cpu_addr_i),
      .cpu_data_i   (cpu_data_i),
      .cpu_rd_i     (cpu_rd_i),
      .cpu_we_i     (cpu_we_i),
      .cpu_data_o   (cpu_data_o),
      .cpu_ack_o    (cpu_ack_o),
      .cpu_fault_o  (cpu_fault_o),
      .fault_addr_o (fault_addr_o),
      .tlb_addr_o   (tlb_addr_o),
      .tlb_lookup_o (tlb_lookup_o),
      .tlb_ent_i    (tlb_ent_i),
      .tlb_ack_i    (tlb_ack_i),
      .tlb_fault_i  (tlb_fault_i),
      .mem_addr_o   (mem_addr_o),
      .mem_data_o   (mem_data_o),
      .mem_data_i   (mem_data_i),
      .mem_rd_o     (mem_rd_o),
      .mem_we_o     (mem_we_o),
      .mem_ack_i    (mem_ack_i)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete CPU access with TLB/bus responders; checks strobes, latency and result.
   task automatic do_xact(input logic pg, input logic we, input logic [31:0] va,
                          input logic [31:0] wd, input logic [31:0] pte, input logic tf,
                          input int tw, input int mw, input logic [31:0] rdat);
      logic [31:0] exp_pa, exp_data;
      logic        exp_flt;
      int          exp_cyc, lc, mc, ack_cyc;
      bit          done;
      exp_flt  = pg && (tf || !pte[0] || (WP_ON && we && !pte[1]));
      exp_pa   = pg ? {pte[31:12], va[11:0]} : va;
      exp_data = (exp_flt || we) ? 32'd0 : rdat;
      exp_cyc  = !pg ? 2 + mw : (exp_flt ? 2 + tw : 3 + tw + mw);
      if (exp_flt) exp_faddr = va;
      paging_en_i = pg;
      cpu_addr_i  = va;
      cpu_data_i  = wd;
      cpu_we_i    = we;
      cpu_rd_i    = !we || ($urandom_range(0, 1) == 1);
      tlb_ent_i   = pte;
      tlb_fault_i = tf;
      lc = 0; mc = 0; ack_cyc = 0; done = 0;
      for (int cyc = 1; cyc <= 60 && !done; cyc++) begin
         step();
         tlb_ack_i  = 1'b0;
         mem_ack_i  = 1'b0;
         mem_data_i = $urandom;
         if (tlb_lookup_o) begin
            lc++;
            n_checks++;
            if (!pg || tlb_addr_o !== va) begin
               n_fail++;
               $display("FAIL lookup: paging=%0b tlb_addr=%h required %h", pg, tlb_addr_o, va);
            end
            tlb_ack_i = (lc == tw + 1);
         end
         if (mem_rd_o || mem_we_o) begin
            mc++;
            n_checks++;
            if (exp_flt || mem_addr_o !== exp_pa || mem_we_o !== we || mem_rd_o !== !we ||
                (we && mem_data_o !== wd)) begin
               n_fail++;
               $display("FAIL bus: addr=%h rd=%0b we=%0b wdata=%h required addr=%h we=%0b wdata=%h fault=%0b",
                        mem_addr_o, mem_rd_o, mem_we_o, mem_data_o, exp_pa, we, wd, exp_flt);
            end
            if (mc == mw + 1) begin
               mem_ack_i  = 1'b1;
               mem_data_i = rdat;
            end
         end
         if (cpu_ack_o) begin
            ack_cyc  = cyc;
            done     = 1;
            cpu_rd_i = 1'b0;
            cpu_we_i = 1'b0;
         end
      end
      if (!done) begin
         n_checks++;
         n_fail++;
         $display("FAIL timeout: no cpu_ack within 60 cycles for va=%h", va);
         cpu_rd_i = 1'b0;
         cpu_we_i = 1'b0;
      end else begin
         n_checks++;
         if (ack_cyc != exp_cyc || cpu_fault_o !== exp_flt || cpu_data_o !== exp_data ||
             fault_addr_o !== exp_faddr) begin
            n_fail++;
            $display("FAIL result: va=%h cyc=%0d fault=%0b data=%h faddr=%h required cyc=%0d fault=%0b data=%h faddr=%h",
                     va, ack_cyc, cpu_fault_o, cpu_data_o, fault_addr_o,
                     exp_cyc, exp_flt, exp_data, exp_faddr);
         end
      end
      step();
      tlb_ack_i   = 1'b0;
      mem_ack_i   = 1'b0;
      tlb_fault_i = 1'b0;
      n_checks++;
      if (cpu_ack_o !== 1'b0 || cpu_fault_o !== 1'b0 || mem_rd_o || mem_we_o || tlb_lookup_o) begin
         n_fail++;
         $display("FAIL after_ack: ack=%0b fault=%0b rd=%0b we=%0b lookup=%0b required all 0",
                  cpu_ack_o, cpu_fault_o, mem_rd_o, mem_we_o, tlb_lookup_o);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      paging_en_i = 0; cpu_addr_i = 0; cpu_data_i = 0; cpu_rd_i = 0; cpu_we_i = 0;
      tlb_ent_i = 0; tlb_ack_i = 0; tlb_fault_i = 0; mem_data_i = 0; mem_ack_i = 0;
      repeat (3) step();
      n_checks++;
      if ({cpu_data_o, fault_addr_o, tlb_addr_o, mem_addr_o, mem_data_o} !== 160'd0 ||
          {cpu_ack_o, cpu_fault_o, tlb_lookup_o, mem_rd_o, mem_we_o} !== 5'd0) begin
         n_fail++;
         $display("FAIL reset: data=%h faddr=%h taddr=%h maddr=%h strobes=%b required all 0",
                  cpu_data_o, fault_addr_o, tlb_addr_o, mem_addr_o,
                  {cpu_ack_o, cpu_fault_o, tlb_lookup_o, mem_rd_o, mem_we_o});
      end
      rst = 1'b0;
      exp_faddr = 32'd0;
      step();
   endtask

   task automatic test_paging_off();
      do_xact(1'b0, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 1'b0, 0, 2, 32'hDEAD_BEEF);
      do_xact(1'b0, 1'b1, 32'h8000_0010, 32'hCAFE_0001, 32'h0, 1'b0, 0, 0, 32'h1111_1111);
      do_xact(1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 0, 0, 32'h5A5A_A5A5);
   endtask

   task automatic test_paging_on();
      do_xact(1'b1, 1'b0, 32'h0040_2ABC, 32'h0, 32'h0009_F001, 1'b0, 3, 0, 32'h1234_5678);
      do_xact(1'b1, 1'b1, 32'h0040_2ABC, 32'hFEED_F00D, 32'h0009_F003, 1'b0, 3, 1, 32'h0);
   endtask

   task automatic test_fault();
      do_xact(1'b1, 1'b0, 32'h0040_2ABC, 32'h0, 32'h0009_F000, 1'b0, 3, 0, 32'h0);
      do_xact(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 32'h0009_F003, 1'b1, 1, 0, 32'h0);
      do_xact(1'b0, 1'b0, 32'h0000_2000, 32'h0, 32'h0, 1'b0, 0, 1, 32'h0BAD_C0DE);
   endtask

   task automatic test_write_protect();
      do_xact(1'b1, 1'b1, 32'h0040_2ABC, 32'h0102_0304, 32'h0009_F001, 1'b0, 2, 0, 32'h0);
      do_xact(1'b1, 1'b1, 32'h0040_2ABC, 32'h0506_0708, 32'h0009_F003, 1'b0, 2, 0, 32'h0);
      do_xact(1'b1, 1'b0, 32'h0040_2ABC, 32'h0, 32'h0009_F001, 1'b0, 0, 0, 32'h7777_0000);
   endtask

   task automatic test_reset_midop();
      bit seen;
      paging_en_i = 1'b0;
      cpu_addr_i  = 32'h0000_5678;
      cpu_rd_i    = 1'b1;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (mem_rd_o) seen = 1;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL midop_start: mem_rd=%0b required 1", mem_rd_o);
      end
      rst = 1'b1;
      cpu_rd_i = 1'b0;
      step();
      n_checks++;
      if (mem_rd_o !== 1'b0 || cpu_ack_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midop_reset: mem_rd=%0b ack=%0b required 0 0", mem_rd_o, cpu_ack_o);
      end
      rst = 1'b0;
      exp_faddr = 32'd0;
      mem_ack_i  = 1'b1;
      mem_data_i = 32'hFFFF_0000;
      step();
      mem_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (cpu_ack_o !== 1'b0 || mem_rd_o !== 1'b0 || cpu_data_o !== 32'd0) begin
            n_fail++;
            $display("FAIL late_ack: ack=%0b rd=%0b data=%h required 0 0 0", cpu_ack_o, mem_rd_o, cpu_data_o);
         end
         step();
      end
   endtask

   task automatic test_stray_ack();
      tlb_ack_i = 1'b1;
      tlb_ent_i = 32'h0009_F001;
      step();
      tlb_ack_i = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (tlb_lookup_o || mem_rd_o || mem_we_o || cpu_ack_o) begin
            n_fail++;
            $display("FAIL stray_ack: lookup=%0b rd=%0b we=%0b ack=%0b required all 0",
                     tlb_lookup_o, mem_rd_o, mem_we_o, cpu_ack_o);
         end
         step();
      end
      do_xact(1'b1, 1'b0, 32'h0012_3456, 32'h0, 32'h00AB_C001, 1'b0, 0, 0, 32'h2468_ACE0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] pte;
      for (int i = 0; i < 40; i++) begin
         pte = $urandom;
         pte[0] = ($urandom_range(0, 5) != 0);
         do_xact($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom, $urandom,
                 pte, $urandom_range(0, 7) == 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      end
   endtask

   initial begin
      test_reset();
      test_paging_off();
      test_paging_on();
      test_fault();
      test_write_protect();
      test_reset_midop();
      test_stray_ack();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
